// File: rtl/mips_mc_datapath.sv
// Multi-cycle MIPS datapath: register file, operand muxing, ALU with SLT
// extension, handshaked memory access and write-back, sequenced by a
// four-state FSM (IDLE -> EXEC -> [MEM] -> WB). One instruction in flight.
module mips_mc_datapath #(
  parameter int WIDTH    = 32,
  parameter int REG_ADDR = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                instr_valid,
  output logic                ready,
  input  logic [REG_ADDR-1:0] rsaddr,
  input  logic [REG_ADDR-1:0] rtaddr,
  input  logic [REG_ADDR-1:0] rt_rd_chosen,
  input  logic [WIDTH-1:0]    shiftImm,
  input  logic [WIDTH-1:0]    S_ZextendImm,
  input  logic                shift_select,
  input  logic                slt_select,
  input  logic                immediate_res,
  input  logic                reg_write,
  input  logic                memread,
  input  logic                memwrite,
  input  logic                alu_mem,
  input  logic [2:0]          alubits,
  output logic                mem_req,
  output logic                mem_we,
  output logic [WIDTH-1:0]    mem_addr,
  output logic [WIDTH-1:0]    mem_wdata,
  input  logic [WIDTH-1:0]    mem_rdata,
  input  logic                mem_ack,
  output logic                branch_result,
  output logic                done
);

  localparam int          SHW   = $clog2(WIDTH);
  localparam int unsigned NREGS = 2 ** REG_ADDR;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM, S_WB} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    regs_q [NREGS];
  logic [WIDTH-1:0]    regs_d [NREGS];
  logic [WIDTH-1:0]    rs_q, rs_d, rt_q, rt_d;
  logic [WIDTH-1:0]    shift_imm_q, shift_imm_d, imm_q, imm_d;
  logic [WIDTH-1:0]    alu_q, alu_d, mem_data_q, mem_data_d;
  logic [REG_ADDR-1:0] rd_q, rd_d;
  logic [2:0]          alubits_q, alubits_d;
  logic                shift_select_q, shift_select_d, slt_select_q, slt_select_d;
  logic                immediate_res_q, immediate_res_d, reg_write_q, reg_write_d;
  logic                memread_q, memread_d, memwrite_q, memwrite_d;
  logic                alu_mem_q, alu_mem_d, branch_q, branch_d;

  logic [WIDTH-1:0]    alu_left, right_l1, alu_right, alu_out;
  logic [WIDTH-1:0]    alu_result, wb_result;
  logic [SHW-1:0]      shamt;

  // ALU on the latched operands, plus SLT extension and write-back select
  always_comb begin
    alu_left  = shift_select_q ? rt_q : rs_q;
    right_l1  = shift_select_q ? shift_imm_q : rt_q;
    alu_right = immediate_res_q ? imm_q : right_l1;
    shamt     = alu_right[SHW-1:0];
    case (alubits_q)
      3'b000:  alu_out = alu_left & alu_right;
      3'b001:  alu_out = alu_left | alu_right;
      3'b010:  alu_out = alu_left + alu_right;
      3'b011:  alu_out = alu_left ^ alu_right;
      3'b100:  alu_out = ~(alu_left | alu_right);
      3'b101:  alu_out = alu_left << shamt;
      3'b110:  alu_out = alu_left - alu_right;
      default: alu_out = alu_left >> shamt;
    endcase
    alu_result = '0;
    if (slt_select_q) alu_result[0] = alu_q[WIDTH-1];
    else              alu_result    = alu_q;
    wb_result = alu_mem_q ? mem_data_q : alu_result;
  end

  // Next-state logic: latch at accept, compute in EXEC, wait in MEM, write in WB
  always_comb begin
    state_d         = state_q;
    regs_d          = regs_q;
    rs_d            = rs_q;
    rt_d            = rt_q;
    shift_imm_d     = shift_imm_q;
    imm_d           = imm_q;
    alu_d           = alu_q;
    mem_data_d      = mem_data_q;
    rd_d            = rd_q;
    alubits_d       = alubits_q;
    shift_select_d  = shift_select_q;
    slt_select_d    = slt_select_q;
    immediate_res_d = immediate_res_q;
    reg_write_d     = reg_write_q;
    memread_d       = memread_q;
    memwrite_d      = memwrite_q;
    alu_mem_d       = alu_mem_q;
    branch_d        = branch_q;
    case (state_q)
      S_IDLE: if (instr_valid) begin
        rs_d            = regs_q[rsaddr];
        rt_d            = regs_q[rtaddr];
        shift_imm_d     = shiftImm;
        imm_d           = S_ZextendImm;
        rd_d            = rt_rd_chosen;
        alubits_d       = alubits;
        shift_select_d  = shift_select;
        slt_select_d    = slt_select;
        immediate_res_d = immediate_res;
        reg_write_d     = reg_write;
        memread_d       = memread;
        memwrite_d      = memwrite;
        alu_mem_d       = alu_mem;
        state_d         = S_EXEC;
      end
      S_EXEC: begin
        alu_d    = alu_out;
        branch_d = alu_out[WIDTH-1];
        state_d  = (memread_q || memwrite_q) ? S_MEM : S_WB;
      end
      S_MEM: if (mem_ack) begin
        mem_data_d = mem_rdata;
        state_d    = S_WB;
      end
      default: begin
        if (reg_write_q && (rd_q != '0)) regs_d[rd_q] = wb_result;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
      rs_q            <= '0;
      rt_q            <= '0;
      shift_imm_q     <= '0;
      imm_q           <= '0;
      alu_q           <= '0;
      mem_data_q      <= '0;
      rd_q            <= '0;
      alubits_q       <= '0;
      shift_select_q  <= 1'b0;
      slt_select_q    <= 1'b0;
      immediate_res_q <= 1'b0;
      reg_write_q     <= 1'b0;
      memread_q       <= 1'b0;
      memwrite_q      <= 1'b0;
      alu_mem_q       <= 1'b0;
      branch_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      regs_q          <= regs_d;
      rs_q            <= rs_d;
      rt_q            <= rt_d;
      shift_imm_q     <= shift_imm_d;
      imm_q           <= imm_d;
      alu_q           <= alu_d;
      mem_data_q      <= mem_data_d;
      rd_q            <= rd_d;
      alubits_q       <= alubits_d;
      shift_select_q  <= shift_select_d;
      slt_select_q    <= slt_select_d;
      immediate_res_q <= immediate_res_d;
      reg_write_q     <= reg_write_d;
      memread_q       <= memread_d;
      memwrite_q      <= memwrite_d;
      alu_mem_q       <= alu_mem_d;
      branch_q        <= branch_d;
    end
  end

  // Handshake outputs decode straight from the state register so a reset
  // drops mem_req without waiting for a clock edge.
  assign ready         = (state_q == S_IDLE);
  assign mem_req       = (state_q == S_MEM);
  assign mem_we        = mem_req & memwrite_q;
  assign mem_addr      = alu_q;
  assign mem_wdata     = rs_q;
  assign branch_result = branch_q;
  assign done          = (state_q == S_WB);

endmodule

// File: tb/tb_mips_mc_datapath.sv
// Directed bench for mips_mc_datapath: a 32-bit and a 16-bit instance share
// the control buses; register contents are observed by issuing stores
// (mem_wdata = rs, mem_addr = rs + 0). Expected values go into a scoreboard
// queue when an instruction is issued and are popped when the DUT shows them.
module tb_mips_mc_datapath;

  localparam logic [6:0] F_SHS = 7'h40, F_SLT = 7'h20, F_IMM = 7'h10, F_RW = 7'h08,
                         F_MR  = 7'h04, F_MW  = 7'h02, F_AM  = 7'h01;
  localparam logic [2:0] OP_OR = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd6, OP_SRL = 3'd7;
  localparam int K_ADDR = 0, K_WDATA = 1, K_WE = 2, K_BR = 3;

  typedef struct {
    int          kind;
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        instr_valid_b, instr_valid_s;
  logic [4:0]  rsaddr, rtaddr, rd;
  logic [31:0] shift_imm, imm, mem_rdata;
  logic        shift_select, slt_select, immediate_res, reg_write, memread, memwrite, alu_mem;
  logic [2:0]  alubits;
  logic        mem_ack;

  logic        b_ready, b_mem_req, b_mem_we, b_branch, b_done;
  logic [31:0] b_mem_addr, b_mem_wdata;
  logic        s_ready, s_mem_req, s_mem_we, s_branch, s_done;
  logic [15:0] s_mem_addr, s_mem_wdata;

  logic        sel;
  logic        o_ready, o_req, o_we, o_done, o_branch;
  logic [31:0] o_addr, o_wdata;

  int   checks = 0, errors = 0;
  int   last_cyc, last_reqs, done_cnt;
  exp_t sb[$];

  mips_mc_datapath #(.WIDTH(32), .REG_ADDR(5)) dut_b (
    .clock(clock), .reset(reset), .instr_valid(instr_valid_b), .ready(b_ready),
    .rsaddr(rsaddr), .rtaddr(rtaddr), .rt_rd_chosen(rd),
    .shiftImm(shift_imm), .S_ZextendImm(imm),
    .shift_select(shift_select), .slt_select(slt_select), .immediate_res(immediate_res),
    .reg_write(reg_write), .memread(memread), .memwrite(memwrite), .alu_mem(alu_mem),
    .alubits(alubits), .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .branch_result(b_branch), .done(b_done));

  mips_mc_datapath #(.WIDTH(16), .REG_ADDR(3)) dut_s (
    .clock(clock), .reset(reset), .instr_valid(instr_valid_s), .ready(s_ready),
    .rsaddr(rsaddr[2:0]), .rtaddr(rtaddr[2:0]), .rt_rd_chosen(rd[2:0]),
    .shiftImm(shift_imm[15:0]), .S_ZextendImm(imm[15:0]),
    .shift_select(shift_select), .slt_select(slt_select), .immediate_res(immediate_res),
    .reg_write(reg_write), .memread(memread), .memwrite(memwrite), .alu_mem(alu_mem),
    .alubits(alubits), .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata[15:0]), .mem_ack(mem_ack),
    .branch_result(s_branch), .done(s_done));

  assign o_ready  = sel ? s_ready   : b_ready;
  assign o_req    = sel ? s_mem_req : b_mem_req;
  assign o_we     = sel ? s_mem_we  : b_mem_we;
  assign o_done   = sel ? s_done    : b_done;
  assign o_branch = sel ? s_branch  : b_branch;
  assign o_addr   = sel ? {16'h0, s_mem_addr}  : b_mem_addr;
  assign o_wdata  = sel ? {16'h0, s_mem_wdata} : b_mem_wdata;

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int kind, input string tag, input logic [31:0] val);
    exp_t e;
    e.kind = kind;
    e.tag  = tag;
    e.val  = val;
    sb.push_back(e);
  endtask

  // Pop the leading memory-side (mem=1) or branch (mem=0) expectations
  task automatic pop_entries(input bit mem);
    exp_t e;
    while (sb.size() > 0 && (mem ? (sb[0].kind != K_BR) : (sb[0].kind == K_BR))) begin
      e = sb.pop_front();
      case (e.kind)
        K_ADDR:  check(e.tag, o_addr, e.val);
        K_WDATA: check(e.tag, o_wdata, e.val);
        K_WE:    check(e.tag, {31'h0, o_we}, e.val);
        default: check(e.tag, {31'h0, o_branch}, e.val);
      endcase
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rdst,
                       input logic [2:0] op, input logic [31:0] shimm,
                       input logic [31:0] immv, input logic [6:0] f);
    rsaddr = rs; rtaddr = rt; rd = rdst; alubits = op; shift_imm = shimm; imm = immv;
    {shift_select, slt_select, immediate_res, reg_write, memread, memwrite, alu_mem} = f;
  endtask

  task automatic wait_ready(input bit sm);
    int n;
    sel = sm;
    n = 0;
    while (!o_ready && n < 20) begin
      step();
      n++;
    end
    check("ready_wait", {31'h0, o_ready}, 32'h1);
  endtask

  // Issue the driven instruction, service memory after req_cycles cycles of
  // mem_req, and return in the WB cycle.
  task automatic exec(input bit sm, input int req_cycles, input logic [31:0] rdata);
    int          cyc, reqs;
    bit          fin;
    logic [31:0] a0, w0;
    wait_ready(sm);
    if (sm) instr_valid_s = 1'b1; else instr_valid_b = 1'b1;
    step();
    instr_valid_s = 1'b0;
    instr_valid_b = 1'b0;
    cyc = 1; reqs = 0; fin = 1'b0; a0 = '0; w0 = '0;
    while (!fin && cyc < 40) begin
      if (o_req) begin
        reqs++;
        if (reqs == 1) begin
          a0 = o_addr;
          w0 = o_wdata;
          pop_entries(1'b1);
        end else begin
          check("req_addr_stable", o_addr, a0);
          check("req_wdata_stable", o_wdata, w0);
        end
        if (reqs == req_cycles) begin
          mem_ack   = 1'b1;
          mem_rdata = rdata;
        end
      end
      if (o_done) begin
        pop_entries(1'b0);
        fin = 1'b1;
      end else begin
        step();
        mem_ack = 1'b0;
        cyc++;
      end
    end
    checks++;
    assert (fin === 1'b1) else begin
      errors++;
      $error("FAIL exec_timeout observed=%0d expected=done", cyc);
    end
    last_cyc  = cyc;
    last_reqs = reqs;
  endtask

  task automatic setreg(input bit sm, input logic [4:0] r, input logic [31:0] v);
    drive(5'd0, 5'd0, r, OP_OR, 32'h0, v, F_IMM | F_RW);
    exec(sm, 1, 32'h0);
  endtask

  task automatic peek(input bit sm, input logic [4:0] r, input logic [31:0] v, input string tag);
    drive(r, 5'd0, 5'd0, OP_ADD, 32'h0, 32'h0, F_IMM | F_MW);
    push(K_WDATA, {tag, "_wdata"}, v);
    push(K_ADDR, {tag, "_addr"}, v);
    exec(sm, 1, 32'h0);
  endtask

  initial begin
    reset = 1'b1; instr_valid_b = 1'b0; instr_valid_s = 1'b0; mem_ack = 1'b0;
    mem_rdata = '0; sel = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 3'd0, 32'h0, 32'h0, 7'h0);
    repeat (2) step();

    // Reset state
    check("rst_ready", {31'h0, b_ready}, 32'h1);
    check("rst_mem_req", {31'h0, b_mem_req}, 32'h0);
    check("rst_mem_we", {31'h0, b_mem_we}, 32'h0);
    check("rst_mem_addr", b_mem_addr, 32'h0);
    check("rst_mem_wdata", b_mem_wdata, 32'h0);
    check("rst_branch", {31'h0, b_branch}, 32'h0);
    check("rst_done", {31'h0, b_done}, 32'h0);
    reset = 1'b0;
    step();

    // ADD with latency check
    setreg(0, 5'd1, 32'd5);
    setreg(0, 5'd2, 32'd7);
    drive(5'd1, 5'd2, 5'd3, OP_ADD, 32'h0, 32'h0, F_RW);
    push(K_BR, "add_br", 32'h0);
    exec(0, 1, 32'h0);
    check("add_done_cycle", last_cyc, 32'd2);
    check("add_ready_in_wb", {31'h0, b_ready}, 32'h0);
    step();
    check("add_ready_after", {31'h0, b_ready}, 32'h1);
    check("add_done_clear", {31'h0, b_done}, 32'h0);
    peek(0, 5'd3, 32'd12, "add_r3");

    // SUB + SLT both orders
    setreg(0, 5'd1, 32'd3);
    setreg(0, 5'd2, 32'd9);
    drive(5'd1, 5'd2, 5'd4, OP_SUB, 32'h0, 32'h0, F_SLT | F_RW);
    push(K_BR, "slt_br_neg", 32'h1);
    exec(0, 1, 32'h0);
    peek(0, 5'd4, 32'd1, "slt_r4_one");
    drive(5'd2, 5'd1, 5'd4, OP_SUB, 32'h0, 32'h0, F_SLT | F_RW);
    push(K_BR, "slt_br_pos", 32'h0);
    exec(0, 1, 32'h0);
    peek(0, 5'd4, 32'd0, "slt_r4_zero");

    // Store with a 3-cycle memory stall, then load back
    setreg(0, 5'd1, 32'hCAFEBABE);
    drive(5'd1, 5'd0, 5'd0, OP_ADD, 32'h0, 32'h10, F_IMM | F_MW);
    push(K_ADDR, "st_addr", 32'hCAFEBACE);
    push(K_WDATA, "st_wdata", 32'hCAFEBABE);
    push(K_WE, "st_we", 32'h1);
    push(K_BR, "st_br", 32'h1);
    exec(0, 3, 32'h0);
    check("st_req_cycles", last_reqs, 32'd3);
    check("st_done_cycle", last_cyc, 32'd5);
    drive(5'd0, 5'd0, 5'd5, OP_ADD, 32'h0, 32'h20, F_IMM | F_MR | F_AM | F_RW);
    push(K_ADDR, "ld_addr", 32'h20);
    push(K_WE, "ld_we", 32'h0);
    exec(0, 2, 32'hCAFEBABE);
    check("ld_req_cycles", last_reqs, 32'd2);
    peek(0, 5'd5, 32'hCAFEBABE, "ld_r5");

    // r0 stays zero
    setreg(0, 5'd0, 32'h55);
    peek(0, 5'd0, 32'h0, "r0_zero");

    // instr_valid held while busy must not start a second instruction
    wait_ready(0);
    drive(5'd1, 5'd2, 5'd6, OP_ADD, 32'h0, 32'h0, F_RW);
    instr_valid_b = 1'b1;
    step();
    drive(5'd0, 5'd0, 5'd7, OP_OR, 32'h0, 32'h77, F_IMM | F_RW);
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (b_done) begin
        done_cnt++;
        instr_valid_b = 1'b0;
      end
      step();
    end
    instr_valid_b = 1'b0;
    check("busy_done_count", done_cnt, 32'd1);
    check("busy_br", {31'h0, b_branch}, 32'h1);
    peek(0, 5'd6, 32'hCAFEBAC7, "busy_r6");
    peek(0, 5'd7, 32'h0, "busy_r7");

    // Reset while stalled in MEM, then a late ack
    wait_ready(0);
    drive(5'd1, 5'd0, 5'd2, OP_ADD, 32'h0, 32'h40, F_IMM | F_MR | F_AM | F_RW);
    instr_valid_b = 1'b1;
    step();
    instr_valid_b = 1'b0;
    step();
    check("mrst_req_before", {31'h0, b_mem_req}, 32'h1);
    step();
    #2 reset = 1'b1;
    #1;
    check("mrst_req", {31'h0, b_mem_req}, 32'h0);
    check("mrst_ready", {31'h0, b_ready}, 32'h1);
    check("mrst_addr", b_mem_addr, 32'h0);
    check("mrst_wdata", b_mem_wdata, 32'h0);
    check("mrst_branch", {31'h0, b_branch}, 32'h0);
    step();
    reset = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'h12345678;
    step();
    mem_ack = 1'b0;
    check("late_ack_done", {31'h0, b_done}, 32'h0);
    check("late_ack_ready", {31'h0, b_ready}, 32'h1);
    step();
    peek(0, 5'd1, 32'h0, "mrst_r1");
    peek(0, 5'd2, 32'h0, "mrst_r2");
    peek(0, 5'd6, 32'h0, "mrst_r6");

    // 16-bit / 8-register instance: SRL by 15 and ADD wrap
    setreg(1, 5'd1, 32'h8000);
    drive(5'd0, 5'd1, 5'd2, OP_SRL, 32'd15, 32'h0, F_SHS | F_RW);
    push(K_BR, "srl16_br", 32'h0);
    exec(1, 1, 32'h0);
    peek(1, 5'd2, 32'h0001, "srl16_r2");
    setreg(1, 5'd3, 32'hFFFF);
    drive(5'd3, 5'd0, 5'd4, OP_ADD, 32'h0, 32'h1, F_IMM | F_RW);
    push(K_BR, "wrap16_br", 32'h0);
    exec(1, 1, 32'h0);
    peek(1, 5'd4, 32'h0000, "wrap16_r4");
    peek(1, 5'd3, 32'hFFFF, "wrap16_r3");

    step();
    check("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
